// File: rtl/key_entry_if.sv
`default_nettype none
// ============================================================================
// key_entry_if : keypad-entry bus (scanner code in, press/entry/value out)
// Rev 1.0
// ============================================================================
interface key_entry_if;
   logic [4:0]  key;
   logic        press_valid;
   logic [3:0]  press_code;
   logic [11:0] entry_bcd;
   logic [1:0]  entry_len;
   logic        busy;
   logic [9:0]  value;
   logic        value_valid;
   logic        range_err;

   modport master (
      output key,
      input  press_valid, press_code, entry_bcd, entry_len, busy,
             value, value_valid, range_err
   );

   modport slave (
      input  key,
      output press_valid, press_code, entry_bcd, entry_len, busy,
             value, value_valid, range_err
   );
endinterface
`default_nettype wire

// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
// key_entry : debounces keypad codes into presses and commits up to 3 BCD
//             digits as a saturated binary value. Auto-repeat: KEY_ENTRY_REPEAT_EN
// Rev 1.0
// ============================================================================
module key_entry #(
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int TIMEOUT_CYCLES  = 480000000,
   parameter int MAX_VALUE       = 999,
   parameter int REPEAT_CYCLES   = 24000000
) (
   input  wire logic   clk,
   input  wire logic   reset_n,
   key_entry_if.slave  bus
);

   localparam int           c_deb_w    = $clog2(DEBOUNCE_CYCLES);
   localparam int           c_to_w     = $clog2(TIMEOUT_CYCLES);
   localparam [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
   localparam [c_deb_w-1:0] c_deb_hit  = c_deb_w'(DEBOUNCE_CYCLES - 2);
   localparam [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
   localparam [9:0]         c_max      = 10'(MAX_VALUE);
   localparam [4:0]         c_key_hash = 5'h1B;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTRY   = 2'd1,
      S_CONVERT = 2'd2
   } state_t;

   // ---------------- debounce ----------------
   logic [4:0]         w_key_n;
   logic [4:0]         r_cand;
   logic [c_deb_w-1:0] r_deb_cnt;
   logic [4:0]         r_acc_code;
   logic               w_accept;
   logic               w_new_press;
   logic               w_rep_fire;
   logic               r_press_valid;
   logic [3:0]         r_press_code;

   // Codes outside 0x10..0x1B are indistinguishable from "no key".
   always_comb begin
      w_key_n = 5'd0;
      if (bus.key[4] && (bus.key[3:0] <= 4'd11))
         w_key_n = bus.key;
   end

   assign w_accept    = (w_key_n == r_cand) && (r_deb_cnt == c_deb_hit);
   assign w_new_press = w_accept && (r_acc_code == 5'd0) && (r_cand != 5'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cand     <= 5'd0;
         r_deb_cnt  <= '0;
         r_acc_code <= 5'd0;
      end else begin
         if (w_key_n != r_cand) begin
            r_cand    <= w_key_n;
            r_deb_cnt <= '0;
         end else if (r_deb_cnt != c_deb_last) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
         if (w_accept)
            r_acc_code <= r_cand;
      end
   end

`ifdef KEY_ENTRY_REPEAT_EN
   localparam int           c_rep_w    = $clog2(REPEAT_CYCLES);
   localparam [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

   logic [c_rep_w-1:0] r_rep_cnt;

   assign w_rep_fire = (r_acc_code != 5'd0) && (r_acc_code != c_key_hash) &&
                       (r_rep_cnt == c_rep_last);

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_rep_cnt <= '0;
      else if (w_new_press || w_rep_fire || (r_acc_code == 5'd0))
         r_rep_cnt <= '0;
      else
         r_rep_cnt <= r_rep_cnt + 1'b1;
   end
`else
   // REPEAT_CYCLES has no role without auto-repeat; this is constant low.
   assign w_rep_fire = (REPEAT_CYCLES < 0);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_press_valid <= 1'b0;
         r_press_code  <= 4'd0;
      end else begin
         r_press_valid <= w_new_press || w_rep_fire;
         if (w_new_press)
            r_press_code <= r_cand[3:0];
         else if (w_rep_fire)
            r_press_code <= r_acc_code[3:0];
      end
   end

   // ---------------- entry FSM ----------------
   state_t            r_state, w_state_nxt;
   logic [11:0]       r_bcd, w_bcd_nxt;
   logic [1:0]        r_len, w_len_nxt;
   logic [11:0]       r_conv_bcd, w_conv_bcd_nxt;
   logic [1:0]        r_conv_left, w_conv_left_nxt;
   logic [9:0]        r_acc, w_acc_nxt;
   logic [c_to_w-1:0] r_idle_cnt, w_idle_nxt;
   logic [9:0]        r_value, w_value_nxt;
   logic              r_value_valid, w_vv_nxt;
   logic              r_range_err, w_rerr_nxt;
   logic              r_busy;
   logic              w_digit;
   logic [9:0]        w_acc_step;

   assign w_digit    = (r_press_code <= 4'd9);
   assign w_acc_step = {r_acc[6:0], 3'b000} + {r_acc[8:0], 1'b0} +
                       {6'd0, r_conv_bcd[11:8]};

   always_comb begin
      w_state_nxt     = r_state;
      w_bcd_nxt       = r_bcd;
      w_len_nxt       = r_len;
      w_conv_bcd_nxt  = r_conv_bcd;
      w_conv_left_nxt = r_conv_left;
      w_acc_nxt       = r_acc;
      w_idle_nxt      = r_idle_cnt;
      w_value_nxt     = r_value;
      w_vv_nxt        = 1'b0;
      w_rerr_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_press_valid && w_digit) begin
               w_bcd_nxt   = {8'd0, r_press_code};
               w_len_nxt   = 2'd1;
               w_idle_nxt  = '0;
               w_state_nxt = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (r_press_valid) begin
               w_idle_nxt = '0;
               if (w_digit) begin
                  if (r_len != 2'd3) begin
                     w_bcd_nxt = {r_bcd[7:0], r_press_code};
                     w_len_nxt = r_len + 2'd1;
                  end
               end else if (r_press_code == 4'd10) begin
                  w_bcd_nxt   = 12'd0;
                  w_len_nxt   = 2'd0;
                  w_state_nxt = S_IDLE;
               end else begin
                  // Left-justify so the most significant digit sits in [11:8].
                  case (r_len)
                     2'd1:    w_conv_bcd_nxt = {r_bcd[3:0], 8'd0};
                     2'd2:    w_conv_bcd_nxt = {r_bcd[7:0], 4'd0};
                     default: w_conv_bcd_nxt = r_bcd;
                  endcase
                  w_conv_left_nxt = r_len;
                  w_acc_nxt       = 10'd0;
                  w_state_nxt     = S_CONVERT;
               end
            end else if (r_idle_cnt == c_to_last) begin
               w_bcd_nxt   = 12'd0;
               w_len_nxt   = 2'd0;
               w_state_nxt = S_IDLE;
            end else begin
               w_idle_nxt = r_idle_cnt + 1'b1;
            end
         end
         S_CONVERT: begin
            w_acc_nxt       = w_acc_step;
            w_conv_bcd_nxt  = {r_conv_bcd[7:0], 4'd0};
            w_conv_left_nxt = r_conv_left - 2'd1;
            if (r_conv_left == 2'd1) begin
               w_value_nxt = (w_acc_step > c_max) ? c_max : w_acc_step;
               w_vv_nxt    = 1'b1;
               w_rerr_nxt  = (w_acc_step > c_max);
               w_bcd_nxt   = 12'd0;
               w_len_nxt   = 2'd0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_bcd         <= 12'd0;
         r_len         <= 2'd0;
         r_conv_bcd    <= 12'd0;
         r_conv_left   <= 2'd0;
         r_acc         <= 10'd0;
         r_idle_cnt    <= '0;
         r_value       <= 10'd0;
         r_value_valid <= 1'b0;
         r_range_err   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_bcd         <= w_bcd_nxt;
         r_len         <= w_len_nxt;
         r_conv_bcd    <= w_conv_bcd_nxt;
         r_conv_left   <= w_conv_left_nxt;
         r_acc         <= w_acc_nxt;
         r_idle_cnt    <= w_idle_nxt;
         r_value       <= w_value_nxt;
         r_value_valid <= w_vv_nxt;
         r_range_err   <= w_rerr_nxt;
         r_busy        <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.press_valid = r_press_valid;
   assign bus.press_code  = r_press_code;
   assign bus.entry_bcd   = r_bcd;
   assign bus.entry_len   = r_len;
   assign bus.busy        = r_busy;
   assign bus.value       = r_value;
   assign bus.value_valid = r_value_valid;
   assign bus.range_err   = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// ============================================================================
// tb_key_entry : scoreboard bench for key_entry (two DUTs, MAX_VALUE 999/500)
// Rev 1.0
// ============================================================================
module tb_key_entry;
   localparam int DEB = 4;
   localparam int TO  = 200;
   localparam int REP = 20;

   typedef struct {
      logic [9:0] v;
      logic       e;
   } vexp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] key_drv = 5'd0;

   key_entry_if ifa ();
   key_entry_if ifb ();
   assign ifa.key = key_drv;
   assign ifb.key = key_drv;

   key_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO), .MAX_VALUE(999),
               .REPEAT_CYCLES(REP))
      u_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
   key_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO), .MAX_VALUE(500),
               .REPEAT_CYCLES(REP))
      u_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    press_seen = 0;
   int    vv_seen_a  = 0;
   logic [3:0] exp_press[$];
   vexp_t      exp_va[$];
   vexp_t      exp_vb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event seen, none expected at %0t", name, $time);
   endtask

   // Monitor: pops expectations whenever a DUT presents a pulse.
   always @(negedge clk) begin
      vexp_t e;
      if (ifa.press_valid) begin
         press_seen++;
         if (exp_press.size() == 0) unexpected("press_valid");
         else check("press_code", ifa.press_code, exp_press.pop_front());
      end
      if (ifa.value_valid) begin
         vv_seen_a++;
         if (exp_va.size() == 0) unexpected("value_valid_a");
         else begin
            e = exp_va.pop_front();
            check("value_a", ifa.value, e.v);
            check("range_err_a", ifa.range_err, e.e);
         end
      end
      if (ifb.value_valid) begin
         if (exp_vb.size() == 0) unexpected("value_valid_b");
         else begin
            e = exp_vb.pop_front();
            check("value_b", ifb.value, e.v);
            check("range_err_b", ifb.range_err, e.e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [4:0] k);
      exp_press.push_back(k[3:0]);
      key_drv = k;
      tick(DEB);
      check("press_timing", ifa.press_valid, 1);
      key_drv = 5'd0;
      tick(DEB + 2);
   endtask

   task automatic commit(input int len);
      exp_press.push_back(4'd11);
      key_drv = 5'h1B;
      tick(DEB);
      check("hash_press_timing", ifa.press_valid, 1);
      key_drv = 5'd0;
      tick(len + 1);
      check("value_valid_timing", ifa.value_valid, 1);
      tick(DEB + 2);
   endtask

   task automatic push_val(input logic [9:0] va, input logic ea,
                           input logic [9:0] vb, input logic eb);
      vexp_t e;
      e.v = va; e.e = ea; exp_va.push_back(e);
      e.v = vb; e.e = eb; exp_vb.push_back(e);
   endtask

   initial begin
      int snap;
      int n_rep;
      logic [11:0] rep_bcd;
      tick(3);
      check("rst_value", ifa.value, 0);
      check("rst_len", ifa.entry_len, 0);
      check("rst_bcd", ifa.entry_bcd, 0);
      check("rst_busy", ifa.busy, 0);
      check("rst_press", ifa.press_valid, 0);
      reset_n = 1'b1;
      tick(2);

      // Glitch shorter than the debounce window.
      snap = press_seen;
      key_drv = 5'h12;
      tick(DEB - 1);
      key_drv = 5'd0;
      tick(8);
      check("glitch_no_press", press_seen, snap);

      // Repeated key needs an accepted release in between.
      press(5'h12);
      check("entry_2", ifa.entry_bcd, 12'h002);
      press(5'h12);
      check("entry_22", ifa.entry_bcd, 12'h022);
      check("len_22", ifa.entry_len, 2);
      press(5'h1A);
      check("star_len", ifa.entry_len, 0);
      check("star_bcd", ifa.entry_bcd, 0);

      press(5'h11); press(5'h12); press(5'h15);
      check("entry_125", ifa.entry_bcd, 12'h125);
      check("len_125", ifa.entry_len, 3);
      check("busy_entry", ifa.busy, 1);
      push_val(10'd125, 1'b0, 10'd125, 1'b0);
      commit(3);
      check("post_value", ifa.value, 125);
      check("post_len", ifa.entry_len, 0);
      check("post_busy", ifa.busy, 0);

      // Fourth digit ignored; saturation on the MAX_VALUE=500 build.
      press(5'h19); press(5'h19); press(5'h19); press(5'h17);
      check("entry_999", ifa.entry_bcd, 12'h999);
      check("len_999", ifa.entry_len, 3);
      push_val(10'd999, 1'b0, 10'd500, 1'b1);
      commit(3);
      check("sat_value_b", ifb.value, 500);
      check("value_a_999", ifa.value, 999);

      // Inactivity timeout.
      snap = vv_seen_a;
      press(5'h14);
      tick(150);
      check("timeout_pending", ifa.entry_len, 1);
      tick(100);
      check("timeout_len", ifa.entry_len, 0);
      check("timeout_busy", ifa.busy, 0);
      press(5'h1B);
      tick(5);
      check("no_value_valid", vv_seen_a, snap);

      // Reset in the middle of a conversion.
      press(5'h18);
      exp_press.push_back(4'd11);
      key_drv = 5'h1B;
      tick(DEB);
      check("hash_press_timing", ifa.press_valid, 1);
      tick(1);
      check("busy_convert", ifa.busy, 1);
      reset_n = 1'b0;
      key_drv = 5'd0;
      tick(2);
      reset_n = 1'b1;
      tick(DEB + 2);
      check("rst_cv_value", ifa.value, 0);
      check("rst_cv_value_b", ifb.value, 0);
      check("rst_cv_len", ifa.entry_len, 0);

      // Held key: auto-repeat only when the feature is built in.
`ifdef KEY_ENTRY_REPEAT_EN
      n_rep = 3; rep_bcd = 12'h333;
`else
      n_rep = 1; rep_bcd = 12'h003;
`endif
      for (int i = 0; i < n_rep; i++) exp_press.push_back(4'd3);
      key_drv = 5'h13;
      tick(DEB);
      check("hold_press_timing", ifa.press_valid, 1);
      tick(50);
      key_drv = 5'd0;
      tick(DEB + 2);
      check("hold_entry", ifa.entry_bcd, rep_bcd);
      press(5'h1A);

      tick(20);
      check("press_queue_empty", exp_press.size(), 0);
      check("value_a_queue_empty", exp_va.size(), 0);
      check("value_b_queue_empty", exp_vb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
